hilo_muldiv_unit: RTL and testbench

HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

---
 rtl/hilo_muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// Purpose : MIPS-style HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Latency : iterative ops take 32 RUN cycles + FIX; done pulses 34 cycles after start
//           (fast multiply with MULDIV_FAST_MUL_EN: done 2 cycles after start).
// Backpressure: none; start/mthi/mtlo are ignored while busy, upstream must stall.
// Ports   : clk, rst (sync, active-high); start, op_div, is_unsigned, rs_val, rt_val,
//           mthi, mtlo in; hi_out, lo_out, busy, done out.
// Config  : define MULDIV_FAST_MUL_EN for a single-cycle 32x32 multiplier (divide unchanged).
`timescale 1ns/1ps
module hilo_muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op_div,
    input  logic        is_unsigned,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mthi,
    input  logic        mtlo,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic        div_q;      // latched operation: 1 = divide
    logic        neg_q;      // negate product/quotient (operand signs differ)
    logic        neg_r;      // negate remainder (dividend negative)
    logic [31:0] a_q;        // multiplicand magnitude or divisor magnitude
    logic [63:0] p_q;        // mul: {acc, multiplier}; div: {remainder, quotient}

    logic        accept;
    logic        launch;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [32:0] mul_sum;
    logic [63:0] p_mul_nxt;
    logic [32:0] div_sh;
    logic        div_ok;
    logic [31:0] div_diff;
    logic [63:0] p_div_nxt;
    logic [63:0] prod_mag;
    logic [63:0] prod;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // DONE behaves like IDLE for accepting new work
    assign accept = (state == IDLE) || (state == DONE);
    assign launch = accept && start;
    assign busy   = (state == RUN) || (state == FIX);
    assign done   = (state == DONE);

    assign rs_mag = (!is_unsigned && rs_val[31]) ? -rs_val : rs_val;
    assign rt_mag = (!is_unsigned && rt_val[31]) ? -rt_val : rt_val;

    // Shift-add step: add multiplicand into the upper half when the low bit is set,
    // then shift the whole register right, keeping the carry.
    assign mul_sum   = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, a_q} : 33'd0);
    assign p_mul_nxt = {mul_sum, p_q[31:1]};

    // Restoring step: shift the next dividend bit into the remainder and subtract
    // the divisor if it fits. The difference is < divisor, so 32 bits suffice.
    assign div_sh    = {p_q[63:32], p_q[31]};
    assign div_ok    = (div_sh >= {1'b0, a_q});
    assign div_diff  = div_sh[31:0] - a_q;
    assign p_div_nxt = div_ok ? {div_diff, p_q[30:0], 1'b1}
                              : {div_sh[31:0], p_q[30:0], 1'b0};

`ifdef MULDIV_FAST_MUL_EN
    assign prod_mag = {32'd0, a_q} * {32'd0, p_q[31:0]};
`else
    assign prod_mag = p_q;
`endif
    assign prod = neg_q ? -prod_mag : prod_mag;

    always_comb begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (div_q) begin
            // Remainder sign follows the dividend; with a zero divisor this yields
            // the original dividend, and the quotient is forced to all ones.
            res_hi = neg_r ? -p_q[63:32] : p_q[63:32];
            if (a_q == 32'd0)
                res_lo = 32'hFFFF_FFFF;
            else
                res_lo = neg_q ? -p_q[31:0] : p_q[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
`ifdef MULDIV_FAST_MUL_EN
                    state_nxt = op_div ? RUN : FIX;
`else
                    state_nxt = RUN;
`endif
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN:     if (cnt == 5'd31) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_out <= 32'd0;
            lo_out <= 32'd0;
            cnt    <= 5'd0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            a_q    <= 32'd0;
            p_q    <= 64'd0;
        end else begin
            if (launch) begin
                // start wins over a simultaneous move
                div_q <= op_div;
                neg_q <= !is_unsigned && (rs_val[31] ^ rt_val[31]);
                neg_r <= !is_unsigned && rs_val[31];
                cnt   <= 5'd0;
                if (op_div) begin
                    a_q <= rt_mag;
                    p_q <= {32'd0, rs_mag};
                end else begin
                    a_q <= rs_mag;
                    p_q <= {32'd0, rt_mag};
                end
            end else if (accept) begin
                if (mthi) hi_out <= rs_val;
                if (mtlo) lo_out <= rs_val;
            end
            if (state == RUN) begin
                cnt <= cnt + 5'd1;
                p_q <= div_q ? p_div_nxt : p_mul_nxt;
            end
            if (state == FIX) begin
                hi_out <= res_hi;
                lo_out <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
`timescale 1ns/1ps
module tb_hilo_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op_div;
    logic        is_unsigned;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mthi;
    logic        mtlo;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;

    int n_chk;
    int n_fail;

    hilo_muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .op_div(op_div),
        .is_unsigned(is_unsigned), .rs_val(rs_val), .rt_val(rt_val),
        .mthi(mthi), .mtlo(mtlo), .hi_out(hi_out), .lo_out(lo_out),
        .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Called at #1 after a rising edge; that cycle is cycle 0 of the operation.
    // Operands are scrambled after launch so a result that tracks the live inputs shows up.
    task automatic launch(input logic dv, input logic uns, input logic [31:0] a,
                          input logic [31:0] b, output int dcyc, output int bcnt);
        start = 1'b1; op_div = dv; is_unsigned = uns; rs_val = a; rt_val = b;
        dcyc = -1;
        bcnt = 0;
        for (int c = 1; c <= 60 && dcyc < 0; c++) begin
            @(posedge clk); #1;
            start = 1'b0; rs_val = 32'hDEAD_BEEF; rt_val = 32'h0BAD_F00D;
            if (done === 1'b1) dcyc = c;
            if (busy === 1'b1) bcnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op_div = 1'b0; is_unsigned = 1'b0;
        rs_val = 32'h0; rt_val = 32'h0; mthi = 1'b0; mtlo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_chk++; if (hi_out !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected %h", hi_out, 32'h0); end
        n_chk++; if (lo_out !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected %h", lo_out, 32'h0); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    endtask

    task automatic test_mult();
        int dc, bc;
        launch(1'b0, 1'b0, 32'hFFFF_FFFE, 32'd3, dc, bc);
        n_chk++; if (dc !== MUL_LAT) begin n_fail++; $display("FAIL mult_done_cycle: got %0d expected %0d", dc, MUL_LAT); end
        n_chk++; if (bc !== MUL_LAT - 1) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d expected %0d", bc, MUL_LAT - 1); end
        n_chk++; if (hi_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected %h", hi_out, 32'hFFFF_FFFF); end
        n_chk++; if (lo_out !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mult_lo: got %h expected %h", lo_out, 32'hFFFF_FFFA); end
        @(posedge clk); #1;
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse_width: got %b expected 0", done); end
        n_chk++; if (hi_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi_hold: got %h expected %h", hi_out, 32'hFFFF_FFFF); end
    endtask

    task automatic test_multu();
        int dc, bc;
        launch(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, bc);
        n_chk++; if (dc !== MUL_LAT) begin n_fail++; $display("FAIL multu_done_cycle: got %0d expected %0d", dc, MUL_LAT); end
        n_chk++; if (hi_out !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h expected %h", hi_out, 32'hFFFF_FFFE); end
        n_chk++; if (lo_out !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h expected %h", lo_out, 32'h1); end
        // signed interpretation of the same bits is (-1)*(-1) = 1
        launch(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, bc);
        n_chk++; if (hi_out !== 32'h0) begin n_fail++; $display("FAIL mult_m1_hi: got %h expected %h", hi_out, 32'h0); end
        n_chk++; if (lo_out !== 32'h1) begin n_fail++; $display("FAIL mult_m1_lo: got %h expected %h", lo_out, 32'h1); end
    endtask

    task automatic test_div();
        int dc, bc;
        launch(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, dc, bc);
        n_chk++; if (dc !== DIV_LAT) begin n_fail++; $display("FAIL div_done_cycle: got %0d expected %0d", dc, DIV_LAT); end
        n_chk++; if (bc !== DIV_LAT - 1) begin n_fail++; $display("FAIL div_busy_cycles: got %0d expected %0d", bc, DIV_LAT - 1); end
        n_chk++; if (lo_out !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo: got %h expected %h", lo_out, 32'hFFFF_FFFD); end
        n_chk++; if (hi_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi: got %h expected %h", hi_out, 32'hFFFF_FFFF); end
        launch(1'b1, 1'b1, 32'd7, 32'd2, dc, bc);
        n_chk++; if (lo_out !== 32'd3) begin n_fail++; $display("FAIL divu_lo: got %h expected %h", lo_out, 32'd3); end
        n_chk++; if (hi_out !== 32'd1) begin n_fail++; $display("FAIL divu_hi: got %h expected %h", hi_out, 32'd1); end
        launch(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, dc, bc);
        n_chk++; if (lo_out !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo: got %h expected %h", lo_out, 32'h8000_0000); end
        n_chk++; if (hi_out !== 32'h0) begin n_fail++; $display("FAIL div_ovf_hi: got %h expected %h", hi_out, 32'h0); end
        launch(1'b1, 1'b0, 32'h1234_5678, 32'd0, dc, bc);
        n_chk++; if (dc !== DIV_LAT) begin n_fail++; $display("FAIL div0_done_cycle: got %0d expected %0d", dc, DIV_LAT); end
        n_chk++; if (lo_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_lo: got %h expected %h", lo_out, 32'hFFFF_FFFF); end
        n_chk++; if (hi_out !== 32'h1234_5678) begin n_fail++; $display("FAIL div0_hi: got %h expected %h", hi_out, 32'h1234_5678); end
        launch(1'b1, 1'b0, 32'h8000_0001, 32'd0, dc, bc);
        n_chk++; if (lo_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_neg_lo: got %h expected %h", lo_out, 32'hFFFF_FFFF); end
        n_chk++; if (hi_out !== 32'h8000_0001) begin n_fail++; $display("FAIL div0_neg_hi: got %h expected %h", hi_out, 32'h8000_0001); end
        launch(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0, dc, bc);
        n_chk++; if (lo_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu0_lo: got %h expected %h", lo_out, 32'hFFFF_FFFF); end
        n_chk++; if (hi_out !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL divu0_hi: got %h expected %h", hi_out, 32'hFFFF_FFF9); end
    endtask

    task automatic test_back_to_back();
        int dc, bc;
        launch(1'b0, 1'b1, 32'h0001_0000, 32'h0001_0000, dc, bc);
        n_chk++; if (hi_out !== 32'h1 || lo_out !== 32'h0) begin n_fail++; $display("FAIL b2b_mul: got hi=%h lo=%h expected hi=1 lo=0", hi_out, lo_out); end
        // launched in the DONE cycle of the previous op
        launch(1'b1, 1'b1, 32'd100, 32'd7, dc, bc);
        n_chk++; if (dc !== DIV_LAT) begin n_fail++; $display("FAIL b2b_div_done_cycle: got %0d expected %0d", dc, DIV_LAT); end
        n_chk++; if (lo_out !== 32'd14 || hi_out !== 32'd2) begin n_fail++; $display("FAIL b2b_div: got hi=%h lo=%h expected hi=2 lo=e", hi_out, lo_out); end
        // move accepted in the DONE cycle
        mthi = 1'b1; rs_val = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mthi = 1'b0;
        n_chk++; if (hi_out !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL done_mthi_hi: got %h expected %h", hi_out, 32'hCAFE_F00D); end
        n_chk++; if (lo_out !== 32'd14) begin n_fail++; $display("FAIL done_mthi_lo: got %h expected %h", lo_out, 32'd14); end
    endtask

    task automatic test_moves();
        int dc;
        mthi = 1'b1; mtlo = 1'b1; rs_val = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0; rs_val = 32'h0;
        n_chk++; if (hi_out !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL move_hi: got %h expected %h", hi_out, 32'hA5A5_A5A5); end
        n_chk++; if (lo_out !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL move_lo: got %h expected %h", lo_out, 32'hA5A5_A5A5); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL move_done: got %b expected 0", done); end
        // start together with mtlo: the move is dropped
        start = 1'b1; mtlo = 1'b1; op_div = 1'b1; is_unsigned = 1'b1; rs_val = 32'd7; rt_val = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; mtlo = 1'b0;
        n_chk++; if (lo_out !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL start_mtlo_drop: got %h expected %h", lo_out, 32'hA5A5_A5A5); end
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_mtlo_busy: got %b expected 1", busy); end
        dc = -1;
        for (int c = 2; c <= 60 && dc < 0; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dc = c;
        end
        n_chk++; if (dc !== DIV_LAT) begin n_fail++; $display("FAIL start_mtlo_done_cycle: got %0d expected %0d", dc, DIV_LAT); end
        n_chk++; if (lo_out !== 32'd3 || hi_out !== 32'd1) begin n_fail++; $display("FAIL start_mtlo_result: got hi=%h lo=%h expected hi=1 lo=3", hi_out, lo_out); end
    endtask

    task automatic test_abort();
        logic [31:0] hi0;
        logic [31:0] lo0;
        int seen_done;
        hi0 = hi_out; lo0 = lo_out;
        start = 1'b1; op_div = 1'b1; is_unsigned = 1'b0; rs_val = 32'd100; rt_val = 32'd7;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            start = 1'b0; mthi = 1'b0;
            if (c == 10) begin
                mthi = 1'b1; start = 1'b1; op_div = 1'b0; rs_val = 32'h1111_1111; rt_val = 32'd5;
            end
            if (c == 11) begin
                n_chk++; if (hi_out !== hi0 || lo_out !== lo0) begin n_fail++; $display("FAIL busy_ignore_moves: got hi=%h lo=%h expected hi=%h lo=%h", hi_out, lo_out, hi0, lo0); end
                n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_mid_op: got %b expected 1", busy); end
            end
            if (c == 20) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        n_chk++; if (hi_out !== 32'h0 || lo_out !== 32'h0) begin n_fail++; $display("FAIL abort_hilo: got hi=%h lo=%h expected 0 0", hi_out, lo_out); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        seen_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) seen_done++;
            @(posedge clk); #1;
        end
        n_chk++; if (seen_done !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen_done); end
        n_chk++; if (hi_out !== 32'h0 || lo_out !== 32'h0) begin n_fail++; $display("FAIL abort_hilo_hold: got hi=%h lo=%h expected 0 0", hi_out, lo_out); end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_back_to_back();
        test_moves();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
